// File: rtl/billiard_pkg.sv
//============================================================================
// Module      : billiard_pkg
// Description : Shared types and constants for the billiard table logic
//               (hole numbering, arming FSM states, hole priority helper).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package billiard_pkg;

  localparam int NUM_HOLES = 6;

  typedef logic [2:0] hole_num_t;

  // Hole number reported when no hole is involved; real holes are 1..6.
  localparam hole_num_t HOLE_NONE = 3'd0;

  // Per-ball arming state: a ball may report at most one hit per visit.
  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } arm_state_t;

  // Lowest-index qualifying hole, numbered 1..NUM_HOLES; HOLE_NONE if none.
  function automatic hole_num_t lowest_hole(input logic [NUM_HOLES-1:0] qual);
    hole_num_t num;
    num = HOLE_NONE;
    for (int i = NUM_HOLES - 1; i >= 0; i--) begin
      if (qual[i]) num = hole_num_t'(i + 1);
    end
    return num;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hole_overlap_counter.sv
//============================================================================
// Module      : hole_overlap_counter
// Description : Per-ball overlap accounting against all holes. Counts
//               ball/hole overlap pixels per frame with saturating counters,
//               decides at the frame boundary whether the ball fell in a
//               hole, and suppresses repeat hits until the ball reappears.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module hole_overlap_counter
  import billiard_pkg::*;
#(
  parameter int HIT_PIXELS = 8,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 start_of_frame,
  input  logic                 ball_dr,
  input  logic [NUM_HOLES-1:0] hole_dr,
  input  logic                 ball_show,
  output logic                 hit,
  output hole_num_t            hole_num
);

  localparam logic [CNT_W-1:0] c_hit_thr = CNT_W'(HIT_PIXELS);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [NUM_HOLES-1:0] w_qual;
  arm_state_t           r_state;
  arm_state_t           w_state_next;
  logic                 r_show_prev;

  generate
    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      // Count visible overlap pixels; clear at frame boundary, never wrap.
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          r_cnt <= '0;
        end else if (start_of_frame) begin
          r_cnt <= '0;
        end else if (ball_dr && hole_dr[i] && ball_show && (r_cnt != c_cnt_max)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_qual[i] = (r_cnt >= c_hit_thr);
    end
  endgenerate

  // Lowest qualifying hole wins when the ball covers several at once.
  assign hole_num = lowest_hole(w_qual);

  // Arming state and previous Show value for rising-edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ARMED;
      r_show_prev <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_show_prev <= ball_show;
    end
  end

  // Fire once per visit; re-arm when the ball is put back on the table.
  always_comb begin
    w_state_next = r_state;
    hit          = 1'b0;
    case (r_state)
      ARMED: begin
        if (start_of_frame && (|w_qual)) begin
          hit          = 1'b1;
          w_state_next = FIRED;
        end
      end
      FIRED: begin
        if (ball_show && !r_show_prev) w_state_next = ARMED;
      end
      default: w_state_next = ARMED;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ball_hole_detector.sv
//============================================================================
// Module      : ball_hole_detector
// Description : Hole-hit event producer for the game controller. Watches the
//               white/red ball and hole draw requests and emits one-cycle
//               hit pulses (plus the red ball's hole number) right after the
//               frame boundary that closes the frame containing the overlap.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ball_hole_detector
  import billiard_pkg::*;
#(
  parameter int HIT_PIXELS = 8,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 whiteBallDR,
  input  logic                 redBallDR,
  input  logic [NUM_HOLES-1:0] holeDR,
  input  logic                 whiteBallShow,
  input  logic                 redBallShow,
  output logic                 whiteBallHoleHit,
  output logic                 redBallHoleHit,
  output hole_num_t            redBallHoleNum
);

  logic      w_white_hit;
  logic      w_red_hit;
  hole_num_t w_red_num;

  hole_overlap_counter #(
    .HIT_PIXELS (HIT_PIXELS),
    .CNT_W      (CNT_W)
  ) u_white (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (startOfFrame),
    .ball_dr        (whiteBallDR),
    .hole_dr        (holeDR),
    .ball_show      (whiteBallShow),
    .hit            (w_white_hit),
    .hole_num       ()
  );

  hole_overlap_counter #(
    .HIT_PIXELS (HIT_PIXELS),
    .CNT_W      (CNT_W)
  ) u_red (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (startOfFrame),
    .ball_dr        (redBallDR),
    .hole_dr        (holeDR),
    .ball_show      (redBallShow),
    .hit            (w_red_hit),
    .hole_num       (w_red_num)
  );

  // Register the frame-boundary decision into single-cycle output pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      whiteBallHoleHit <= 1'b0;
      redBallHoleHit   <= 1'b0;
      redBallHoleNum   <= HOLE_NONE;
    end else begin
      whiteBallHoleHit <= w_white_hit;
      redBallHoleHit   <= w_red_hit;
      redBallHoleNum   <= w_red_hit ? w_red_num : HOLE_NONE;
    end
  end

endmodule

`default_nettype wire
